id_decode_reg: RTL
==================

// Module: id_decode_reg
// PURPOSE
//  ID-stage decoder and ID/EX pipeline register; producer of alu_ctrl_t for the EX ALU.
//  Decodes one RV32I instruction per cycle into ALU control, immediate, register indices and control flags.
//  Registers all results behind a valid/ready handshake with stall and flush.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported.
// PORTS
//  i_clk       in   1     clock; all state updates on the rising edge
//  i_rst       in   1     asynchronous, active-high reset
//  i_valid     in   1     IF/ID holds a valid instruction
//  i_instr     in   32    instruction word
//  i_pc        in   32    PC of i_instr
//  o_ready     out  1     block accepts i_instr this cycle
//  i_flush     in   1     kill the ID/EX contents (branch/jump redirect)
//  o_valid     out  1     ID/EX register holds a valid op
//  i_exReady   in   1     EX consumes the op this cycle
//  o_ctrlALU   out  12    alu_ctrl_t {aluOp[1:0], func3[2:0], func7[6:0]}
//  o_imm       out  32    sign-extended immediate
//  o_aluSrcA   out  2     ALU A select: 0=rs1, 1=pc, 2=zero
//  o_aluSrcB   out  1     ALU B select: 0=rs2, 1=imm
//  o_rs1/o_rs2 out  5     source registers; 0 when the format has no such field
//  o_rd        out  5     destination register; 0 when o_regWrite=0
//  o_regWrite, o_memRead, o_memWrite, o_branch, o_jump  out 1 each
//  o_illegal   out  1     op is illegal; all enables forced 0
//  o_pc        out  32    registered i_pc
// BEHAVIOUR
//  - o_ready = !o_valid | i_exReady (combinational). Capture occurs when i_valid & o_ready.
//  - Latency: 1 cycle from capture to o_valid=1.
//  - Stall: while o_valid & !i_exReady, all outputs hold bit-stable.
//  - Next o_valid:
//    - 0 if i_flush;
//    - else 1 on capture;
//    - else 0 if i_exReady;
//    - else hold.
//  - i_flush wins over a simultaneous capture; the incoming instr is dropped (IF must re-present it).
//  - Reset (async, any time): o_valid and every registered output go to 0; o_ready=1 once reset is released.
//  - Fields that are not captured hold their value; only o_valid qualifies them.
//  - aluOp by opcode:
//    - LOAD 0000011 / STORE 0100011 / LUI / AUIPC / JAL / JALR -> 00
//    - BRANCH 1100011 -> 01
//    - OP 0110011 / OP-IMM 0010011 -> 10
//  - func3 = instr[14:12] for every opcode except LUI, AUIPC, JAL, which use 000.
//  - func7:
//    - OP: instr[31:25]
//    - OP-IMM: instr[31:25] only when func3=001/101, else 0000000 (ADDI must not decode as SUB)
//    - all other opcodes: 0000000
//  - Immediate formats (all sign-extended from instr[31]):
//    - I: LOAD, OP-IMM, JALR
//    - S: STORE
//    - B: BRANCH, bit0=0
//    - U: LUI, AUIPC; {instr[31:12], 12'b0}
//    - J: JAL, bit0=0
//    - OP: imm = 0
//  - Operand selects:
//    - aluSrcA: pc for AUIPC/JAL; zero for LUI; rs1 otherwise
//    - aluSrcB: imm for all except OP and BRANCH
//  - Enables:
//    - regWrite: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR
//    - memRead: LOAD; memWrite: STORE
//    - branch: BRANCH; jump: JAL, JALR
//  - Illegal (o_illegal=1; all enables and o_ctrlALU forced 0; still propagated with o_valid):
//    - unknown opcode
//    - OP with func7 not 0x00/0x20
//    - OP with func7=0x20 and func3 not 000/101
//    - OP-IMM func3=001 with func7!=0
//    - OP-IMM func3=101 with func7 not 0x00/0x20
//    - BRANCH func3 010/011
//    - LOAD func3 011/110/111
//    - STORE func3 >= 011
//    - JALR func3 != 000
//  - rd=x0 on a writing op keeps regWrite=1 (the register file ignores x0).
// TESTING
//  - ADD 0x002081B3, exReady=1 -> next cycle: valid=1, ctrlALU={10,000,0000000}, rs1=1, rs2=2, rd=3, regWrite=1, aluSrcB=0.
//  - ADDI 0xFFF00093 -> imm=0xFFFFFFFF, func7=0000000, aluSrcB=1, rd=1.
//  - SRAI 0x40335293 -> func3=101, func7=0100000, imm[4:0]=3, rs2=0.
//  - SW 0x0020A423 -> aluOp=00, imm=8, memWrite=1, regWrite=0, rd=0, rs2=2.
//  - Stall: exReady=0 for 3 cycles with new i_valid -> outputs unchanged, o_ready=0.
//    Then exReady=1 -> new instr captured next edge.
//  - Flush + capture same cycle -> o_valid=0 next cycle.
//    0x00000000 -> o_illegal=1, all enables 0.
//    i_rst asserted mid-stall -> o_valid=0 immediately, no clock edge required.

Source files
------------

// File: rtl/id_decode_reg_if.sv
// IF/ID -> ID -> EX handshake and decoded-op bundle for id_decode_reg.
// The slave side is the decoder/register; the master side is the surrounding pipeline.
interface id_decode_reg_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            o_ready;
  logic            i_flush;
  logic            o_valid;
  logic            i_exReady;
  logic [11:0]     o_ctrlALU;
  logic [XLEN-1:0] o_imm;
  logic [1:0]      o_aluSrcA;
  logic            o_aluSrcB;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [4:0]      o_rd;
  logic            o_regWrite;
  logic            o_memRead;
  logic            o_memWrite;
  logic            o_branch;
  logic            o_jump;
  logic            o_illegal;
  logic [XLEN-1:0] o_pc;

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_exReady,
    input  o_ready, o_valid, o_ctrlALU, o_imm, o_aluSrcA, o_aluSrcB, o_rs1, o_rs2, o_rd,
           o_regWrite, o_memRead, o_memWrite, o_branch, o_jump, o_illegal, o_pc
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_exReady,
    output o_ready, o_valid, o_ctrlALU, o_imm, o_aluSrcA, o_aluSrcB, o_rs1, o_rs2, o_rd,
           o_regWrite, o_memRead, o_memWrite, o_branch, o_jump, o_illegal, o_pc
  );
endinterface

// File: rtl/id_decode_reg.sv
// RV32I ID-stage decoder plus ID/EX pipeline register with valid/ready, stall and flush.
// o_ctrlALU packs alu_ctrl_t as {aluOp[1:0], func3[2:0], func7[6:0]}.
module id_decode_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  id_decode_reg_if.slave  bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3_in;
  logic [6:0]  w_f7_in;

  logic [1:0]      w_alu_op;
  logic [2:0]      w_func3;
  logic [6:0]      w_func7;
  logic [XLEN-1:0] w_imm;
  logic [1:0]      w_src_a;
  logic            w_src_b;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_branch;
  logic            w_jump;
  logic            w_illegal;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;

  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  logic w_ready;
  logic w_capture;

  assign w_instr  = bus.i_instr;
  assign w_opcode = w_instr[6:0];
  assign w_f3_in  = w_instr[14:12];
  assign w_f7_in  = w_instr[31:25];

  assign w_imm_i = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  always_comb begin
    w_alu_op    = 2'b00;
    w_func3     = 3'b000;
    w_func7     = 7'b0;
    w_imm       = '0;
    w_src_a     = 2'd0;
    w_src_b     = 1'b0;
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OpLoad: begin
        w_func3     = w_f3_in;
        w_imm       = w_imm_i;
        w_src_b     = 1'b1;
        w_use_rs1   = 1'b1;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
        w_illegal   = (w_f3_in == 3'b011) || (w_f3_in == 3'b110) || (w_f3_in == 3'b111);
      end
      OpStore: begin
        w_func3     = w_f3_in;
        w_imm       = w_imm_s;
        w_src_b     = 1'b1;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_mem_write = 1'b1;
        w_illegal   = (w_f3_in >= 3'b011);
      end
      OpLui: begin
        w_imm       = w_imm_u;
        w_src_a     = 2'd2;
        w_src_b     = 1'b1;
        w_reg_write = 1'b1;
      end
      OpAuipc: begin
        w_imm       = w_imm_u;
        w_src_a     = 2'd1;
        w_src_b     = 1'b1;
        w_reg_write = 1'b1;
      end
      OpJal: begin
        w_imm       = w_imm_j;
        w_src_a     = 2'd1;
        w_src_b     = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      OpJalr: begin
        w_func3     = w_f3_in;
        w_imm       = w_imm_i;
        w_src_b     = 1'b1;
        w_use_rs1   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_illegal   = (w_f3_in != 3'b000);
      end
      OpBranch: begin
        w_alu_op  = 2'b01;
        w_func3   = w_f3_in;
        w_imm     = w_imm_b;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_branch  = 1'b1;
        w_illegal = (w_f3_in == 3'b010) || (w_f3_in == 3'b011);
      end
      OpOp: begin
        w_alu_op    = 2'b10;
        w_func3     = w_f3_in;
        w_func7     = w_f7_in;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_reg_write = 1'b1;
        w_illegal   = ((w_f7_in != 7'h00) && (w_f7_in != 7'h20)) ||
                      ((w_f7_in == 7'h20) && (w_f3_in != 3'b000) && (w_f3_in != 3'b101));
      end
      OpImm: begin
        w_alu_op    = 2'b10;
        w_func3     = w_f3_in;
        // Only shifts carry a func7; ADDI's upper imm bits must not look like SUB.
        w_func7     = ((w_f3_in == 3'b001) || (w_f3_in == 3'b101)) ? w_f7_in : 7'b0;
        w_imm       = w_imm_i;
        w_src_b     = 1'b1;
        w_use_rs1   = 1'b1;
        w_reg_write = 1'b1;
        w_illegal   = ((w_f3_in == 3'b001) && (w_f7_in != 7'h00)) ||
                      ((w_f3_in == 3'b101) && (w_f7_in != 7'h00) && (w_f7_in != 7'h20));
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal) begin
      w_alu_op    = 2'b00;
      w_func3     = 3'b000;
      w_func7     = 7'b0;
      w_imm       = '0;
      w_src_a     = 2'd0;
      w_src_b     = 1'b0;
      w_use_rs1   = 1'b0;
      w_use_rs2   = 1'b0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_branch    = 1'b0;
      w_jump      = 1'b0;
    end

    w_rs1 = w_use_rs1   ? w_instr[19:15] : 5'd0;
    w_rs2 = w_use_rs2   ? w_instr[24:20] : 5'd0;
    w_rd  = w_reg_write ? w_instr[11:7]  : 5'd0;
  end

  logic            r_valid;
  logic [11:0]     r_ctrl_alu;
  logic [XLEN-1:0] r_imm;
  logic [1:0]      r_src_a;
  logic            r_src_b;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_jump;
  logic            r_illegal;
  logic [XLEN-1:0] r_pc;

  assign w_ready   = !r_valid || bus.i_exReady;
  // A flushed capture is dropped entirely so the held fields stay bit-stable.
  assign w_capture = bus.i_valid && w_ready && !bus.i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (bus.i_exReady) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl_alu  <= '0;
      r_imm       <= '0;
      r_src_a     <= '0;
      r_src_b     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= '0;
    end else if (w_capture) begin
      r_ctrl_alu  <= {w_alu_op, w_func3, w_func7};
      r_imm       <= w_imm;
      r_src_a     <= w_src_a;
      r_src_b     <= w_src_b;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_reg_write <= w_reg_write;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= w_illegal;
      r_pc        <= bus.i_pc;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_ctrlALU  = r_ctrl_alu;
  assign bus.o_imm      = r_imm;
  assign bus.o_aluSrcA  = r_src_a;
  assign bus.o_aluSrcB  = r_src_b;
  assign bus.o_rs1      = r_rs1;
  assign bus.o_rs2      = r_rs2;
  assign bus.o_rd       = r_rd;
  assign bus.o_regWrite = r_reg_write;
  assign bus.o_memRead  = r_mem_read;
  assign bus.o_memWrite = r_mem_write;
  assign bus.o_branch   = r_branch;
  assign bus.o_jump     = r_jump;
  assign bus.o_illegal  = r_illegal;
  assign bus.o_pc       = r_pc;

endmodule
